// File: rtl/keypad_scan_controller_if.sv
// FIFO-side bus of the keypad scan controller: one entry per accepted key,
// plus the interrupt and overflow pulses that travel with it.
interface keypad_scan_controller_if;
  logic       fifo_full_i;
  logic       fifo_write_o;
  logic [5:0] position_o;
  logic [7:0] ascii_o;
  logic       key_press_interrupt_o;
  logic       overflow_o;

  // Controller side: drives the entry, observes FIFO full.
  modport master (
    input  fifo_full_i,
    output fifo_write_o,
    output position_o,
    output ascii_o,
    output key_press_interrupt_o,
    output overflow_o
  );

  // FIFO / register-block side.
  modport slave (
    output fifo_full_i,
    input  fifo_write_o,
    input  position_o,
    input  ascii_o,
    input  key_press_interrupt_o,
    input  overflow_o
  );
endinterface

// File: rtl/keypad_scan_controller.sv
// 4x4 active-low keypad scanner: walks the rows on a divided tick, debounces
// a detected column, emits one FIFO entry per press and waits for release.
module keypad_scan_controller #(
  parameter int DIV_W = 20,
  parameter int DEB_W = 8
) (
  input  logic                 system_clk,
  input  logic                 sys_reset,
  input  logic [DIV_W-1:0]     clk_divider_limit_i,
  input  logic [DEB_W-1:0]     debounce_limit_i,
  input  logic [3:0]           scan_timeout_limit_i,
  input  logic [3:0]           col_i,
  output logic [3:0]           row_o,
  keypad_scan_controller_if.master fifo_if
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PUSH, WAIT_RELEASE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         row_q, row_d;
  logic [1:0]         col_q, col_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [3:0]         dwell_cnt_q, dwell_cnt_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic [DEB_W-1:0]   rel_cnt_q, rel_cnt_d;
  logic [3:0]         col_s1_q, col_s2_q;
  logic [3:0]         row_o_q;
  logic               push_q, push_d;
  logic [5:0]         position_q, position_d;
  logic [7:0]         ascii_q, ascii_d;
  logic               tick;

  // Lowest-index active-low column wins when several are pressed together.
  function automatic logic [1:0] lowest_low(input logic [3:0] c);
    if (!c[0])      return 2'd0;
    else if (!c[1]) return 2'd1;
    else if (!c[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  // Legend of the keypad: "123A" / "456B" / "789C" / "*0#D".
  function automatic logic [7:0] key_ascii(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 8'h31;
      4'h1: return 8'h32;
      4'h2: return 8'h33;
      4'h3: return 8'h41;
      4'h4: return 8'h34;
      4'h5: return 8'h35;
      4'h6: return 8'h36;
      4'h7: return 8'h42;
      4'h8: return 8'h37;
      4'h9: return 8'h38;
      4'hA: return 8'h39;
      4'hB: return 8'h43;
      4'hC: return 8'h2A;
      4'hD: return 8'h30;
      4'hE: return 8'h23;
      default: return 8'h44;
    endcase
  endfunction

  // Scan tick: >= compare so a live-lowered limit takes effect at once.
  always_comb begin
    tick      = (div_cnt_q >= clk_divider_limit_i);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
  end

  // Next-state logic for scanning, debounce, push and release wait.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    dwell_cnt_d = dwell_cnt_q;
    deb_cnt_d   = deb_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    push_d      = 1'b0;
    position_d  = position_q;
    ascii_d     = ascii_q;
    case (state_q)
      SCAN: begin
        if (tick) begin
          if (col_s2_q != 4'hF) begin
            col_d     = lowest_low(col_s2_q);
            deb_cnt_d = '0;
            state_d   = DEBOUNCE;
          end else if (dwell_cnt_q >= scan_timeout_limit_i) begin
            row_d       = row_q + 2'd1;
            dwell_cnt_d = '0;
          end else begin
            dwell_cnt_d = dwell_cnt_q + 4'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (!col_s2_q[col_q]) begin
            if (deb_cnt_q >= debounce_limit_i) begin
              state_d    = PUSH;
              push_d     = 1'b1;
              position_d = {1'b0, row_q, 1'b0, col_q};
              ascii_d    = key_ascii(row_q, col_q);
            end else begin
              deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
          end else begin
            state_d     = SCAN;
            dwell_cnt_d = '0;
          end
        end
      end
      PUSH: begin
        state_d   = WAIT_RELEASE;
        rel_cnt_d = '0;
      end
      default: begin
        if (tick) begin
          if (col_s2_q[col_q]) begin
            if (rel_cnt_q >= debounce_limit_i) begin
              row_d       = row_q + 2'd1;
              dwell_cnt_d = '0;
              state_d     = SCAN;
            end else begin
              rel_cnt_d = rel_cnt_q + DEB_W'(1);
            end
          end else begin
            rel_cnt_d = '0;
          end
        end
      end
    endcase
  end

  // State, counters, column synchronizer and registered outputs.
  always_ff @(posedge system_clk) begin
    if (sys_reset) begin
      state_q     <= SCAN;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      div_cnt_q   <= '0;
      dwell_cnt_q <= '0;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      col_s1_q    <= 4'hF;
      col_s2_q    <= 4'hF;
      row_o_q     <= 4'b1110;
      push_q      <= 1'b0;
      position_q  <= '0;
      ascii_q     <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      div_cnt_q   <= div_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      col_s1_q    <= col_i;
      col_s2_q    <= col_s1_q;
      row_o_q     <= ~(4'b0001 << row_d);
      push_q      <= push_d;
      position_q  <= position_d;
      ascii_q     <= ascii_d;
    end
  end

  // The push flag is a flop marking the PUSH cycle; FIFO full is looked at
  // only in that same cycle, so the strobe lands the cycle after the confirm tick.
  assign row_o                         = row_o_q;
  assign fifo_if.fifo_write_o          = push_q & ~fifo_if.fifo_full_i;
  assign fifo_if.key_press_interrupt_o = push_q & ~fifo_if.fifo_full_i;
  assign fifo_if.overflow_o            = push_q & fifo_if.fifo_full_i;
  assign fifo_if.position_o            = position_q;
  assign fifo_if.ascii_o               = ascii_q;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller: directed vector table, hand-written
// corner sequences and random presses scored against an entry-level model.
module tb_keypad_scan_controller;

  logic        clk;
  logic        rst;
  logic [19:0] div_lim;
  logic [7:0]  deb_lim;
  logic [3:0]  dwell_lim;
  logic [3:0]  col;
  logic [3:0]  row;
  bit          pressed [16];

  keypad_scan_controller_if bus ();

  keypad_scan_controller #(.DIV_W(20), .DEB_W(8)) dut (
    .system_clk           (clk),
    .sys_reset            (rst),
    .clk_divider_limit_i  (div_lim),
    .debounce_limit_i     (deb_lim),
    .scan_timeout_limit_i (dwell_lim),
    .col_i                (col),
    .row_o                (row),
    .fifo_if              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  typedef struct {
    bit         ovf;
    logic [5:0] pos;
    logic [7:0] asc;
  } exp_t;

  typedef struct {
    int         div;
    int         deb;
    int         dwell;
    int         r;
    logic [3:0] mask;
    bit         full;
    logic [5:0] pos;
    logic [7:0] asc;
  } vec_t;

  exp_t  exp_q[$];
  int    checks, failures;
  int    mon_writes, mon_ovfs;
  bit    prev_write;
  int    cur_div, cur_deb, cur_dwell;
  string legend = "123A456B789C*0#D";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Per-cycle scoreboard of the FIFO-side bus.
  task automatic mon();
    exp_t e;
    if (rst) begin
      prev_write = 1'b0;
      return;
    end
    check("irq_with_write", 32'(bus.key_press_interrupt_o), 32'(bus.fifo_write_o));
    if (bus.fifo_write_o) begin
      mon_writes++;
      $display("write pos=%02h ascii=%02h", bus.position_o, bus.ascii_o);
      check("write_width", 32'(prev_write), 32'd0);
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("write_not_overflow", 32'(e.ovf), 32'd0);
        check("position", 32'(bus.position_o), 32'(e.pos));
        check("ascii", 32'(bus.ascii_o), 32'(e.asc));
      end
    end
    if (bus.overflow_o) begin
      mon_ovfs++;
      $display("overflow pos=%02h", bus.position_o);
      check("overflow_no_write", 32'(bus.fifo_write_o), 32'd0);
      check("overflow_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("overflow_kind", 32'(e.ovf), 32'd1);
      end
    end
    prev_write = bus.fifo_write_o;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      mon();
    end
  endtask

  task automatic set_limits(input int d, input int b, input int w);
    cur_div = d; cur_deb = b; cur_dwell = w;
    div_lim = 20'(d); deb_lim = 8'(b); dwell_lim = 4'(w);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    exp_q.delete();
  endtask

  function automatic int hold_cycles();
    return (4 * (cur_dwell + 1) + cur_deb + 8) * (cur_div + 1) + 6;
  endfunction

  function automatic int rel_cycles();
    return (cur_deb + 3) * (cur_div + 1) + 6;
  endfunction

  task automatic set_key(input int r, input logic [3:0] mask, input bit on);
    for (int c = 0; c < 4; c++)
      if (mask[c]) pressed[r*4+c] = on;
  endtask

  task automatic run_press(input int r, input logic [3:0] mask, input bit full,
                           input int hold, input int rel);
    bus.fifo_full_i = full;
    set_key(r, mask, 1'b1);
    step(hold);
    set_key(r, mask, 1'b0);
    step(rel);
    bus.fifo_full_i = 1'b0;
  endtask

  task automatic expect_entry(input bit ovf, input logic [5:0] pos, input logic [7:0] asc);
    exp_t e;
    e.ovf = ovf; e.pos = pos; e.asc = asc;
    exp_q.push_back(e);
  endtask

  vec_t vecs[7];

  initial begin
    int w0, o0;
    bit saw_row1;
    checks = 0; failures = 0; mon_writes = 0; mon_ovfs = 0; prev_write = 1'b0;
    for (int i = 0; i < 16; i++) pressed[i] = 1'b0;
    bus.fifo_full_i = 1'b0;
    rst = 1'b1;
    set_limits(3, 2, 1);

    // Reset values and first row advance after (dwell+1)*(div+1) cycles.
    step(3);
    check("reset_row", 32'(row), 32'h0000000E);
    check("reset_write", 32'(bus.fifo_write_o), 32'd0);
    check("reset_irq", 32'(bus.key_press_interrupt_o), 32'd0);
    check("reset_overflow", 32'(bus.overflow_o), 32'd0);
    check("reset_position", 32'(bus.position_o), 32'd0);
    check("reset_ascii", 32'(bus.ascii_o), 32'd0);
    rst = 1'b0;
    step(7);
    check("row_before_advance", 32'(row), 32'h0000000E);
    step(1);
    check("row_advance", 32'(row), 32'h0000000D);

    // Directed vector table with constant expectations.
    vecs[0] = '{div:3, deb:2, dwell:0, r:2, mask:4'b0010, full:1'b0, pos:6'h11, asc:8'h38};
    vecs[1] = '{div:3, deb:2, dwell:0, r:0, mask:4'b1000, full:1'b1, pos:6'h03, asc:8'h41};
    vecs[2] = '{div:2, deb:1, dwell:1, r:1, mask:4'b0110, full:1'b0, pos:6'h09, asc:8'h35};
    vecs[3] = '{div:4, deb:3, dwell:2, r:3, mask:4'b1111, full:1'b0, pos:6'h18, asc:8'h2A};
    vecs[4] = '{div:2, deb:0, dwell:0, r:3, mask:4'b0100, full:1'b0, pos:6'h1A, asc:8'h23};
    vecs[5] = '{div:3, deb:1, dwell:0, r:0, mask:4'b0001, full:1'b0, pos:6'h00, asc:8'h31};
    vecs[6] = '{div:2, deb:2, dwell:1, r:2, mask:4'b1000, full:1'b0, pos:6'h13, asc:8'h43};
    for (int i = 0; i < 7; i++) begin
      set_limits(vecs[i].div, vecs[i].deb, vecs[i].dwell);
      w0 = mon_writes; o0 = mon_ovfs;
      expect_entry(vecs[i].full, vecs[i].pos, vecs[i].asc);
      run_press(vecs[i].r, vecs[i].mask, vecs[i].full, hold_cycles(), rel_cycles());
      check("vec_writes", 32'(mon_writes - w0), vecs[i].full ? 32'd0 : 32'd1);
      check("vec_overflows", 32'(mon_ovfs - o0), vecs[i].full ? 32'd1 : 32'd0);
      check("vec_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // Bounce: only two low ticks with deb=2 gives no entry; scanning resumes.
    set_limits(3, 2, 15);
    do_reset();
    w0 = mon_writes; o0 = mon_ovfs;
    set_key(0, 4'b0100, 1'b1);
    step(8);
    set_key(0, 4'b0100, 1'b0);
    saw_row1 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (row == 4'b1101) saw_row1 = 1'b1;
    end
    check("bounce_no_write", 32'(mon_writes - w0), 32'd0);
    check("bounce_no_overflow", 32'(mon_ovfs - o0), 32'd0);
    check("bounce_scan_resumes", 32'(saw_row1), 32'd1);

    // Hold for 50 ticks, release for 3 ticks, press again: two entries.
    set_limits(3, 2, 0);
    w0 = mon_writes;
    expect_entry(1'b0, 6'h18, 8'h2A);
    expect_entry(1'b0, 6'h18, 8'h2A);
    set_key(3, 4'b0001, 1'b1);
    step(200);
    set_key(3, 4'b0001, 1'b0);
    step(15);
    set_key(3, 4'b0001, 1'b1);
    step(100);
    set_key(3, 4'b0001, 1'b0);
    step(40);
    check("repress_writes", 32'(mon_writes - w0), 32'd2);
    check("repress_queue_empty", 32'(exp_q.size()), 32'd0);

    // Edge limits div=0, deb=0: cols 1 and 2 of row1 held together.
    set_limits(0, 0, 3);
    rst = 1'b1;
    set_key(1, 4'b0110, 1'b1);
    do_reset();
    w0 = mon_writes;
    expect_entry(1'b0, 6'h09, 8'h35);
    step(30);
    set_key(1, 4'b0110, 1'b0);
    step(30);
    check("edge_writes", 32'(mon_writes - w0), 32'd1);
    check("edge_queue_empty", 32'(exp_q.size()), 32'd0);

    // Random presses against the entry-level model.
    for (int it = 0; it < 20; it++) begin
      int r, lc;
      logic [3:0] mask;
      bit full;
      set_limits($urandom_range(2, 4), $urandom_range(0, 3), $urandom_range(0, 2));
      r    = $urandom_range(0, 3);
      mask = 4'($urandom_range(1, 15));
      full = ($urandom_range(0, 3) == 0);
      lc = 0;
      for (int c = 3; c >= 0; c--) if (mask[c]) lc = c;
      w0 = mon_writes; o0 = mon_ovfs;
      expect_entry(full, 6'(r * 8 + lc), 8'(legend.getc(r * 4 + lc)));
      run_press(r, mask, full, hold_cycles(), rel_cycles());
      check("rand_writes", 32'(mon_writes - w0), full ? 32'd0 : 32'd1);
      check("rand_overflows", 32'(mon_ovfs - o0), full ? 32'd1 : 32'd0);
      check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
